// File: rtl/cargo_load_accumulator.sv
// Accumulates 8-bit product beats into a saturating load total and reports
// total, entry count and a sticky over-limit flag per manifest.
module cargo_load_accumulator #(
  parameter int ACC_W       = 12,
  parameter int LIMIT       = 1000,
  parameter int MAX_ENTRIES = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [3:0]       out_entries,
  output logic             out_over,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [ACC_W:0] LIMIT_X   = LIMIT[ACC_W:0];
  localparam logic [3:0]     MAX_ENT_4 = MAX_ENTRIES[3:0];

  state_t           state, state_nxt;
  logic             accept;
  logic             close_beat;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] total_sat;
  logic [3:0]       entries_inc;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && (state == ACCUM);

  // Sum one bit wider than the total so the carry drives saturation.
  always_comb begin
    sum         = {1'b0, out_total} + {{(ACC_W-7){1'b0}}, in_data};
    total_sat   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    entries_inc = out_entries + 4'd1;
    close_beat  = in_last || (entries_inc == MAX_ENT_4);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && close_beat) state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Report fields stay visible in IDLE until the next start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_total   <= '0;
      out_entries <= '0;
      out_over    <= 1'b0;
    end else if (state == IDLE && start) begin
      out_total   <= '0;
      out_entries <= '0;
      out_over    <= 1'b0;
    end else if (accept) begin
      out_total   <= total_sat;
      out_entries <= entries_inc;
      out_over    <= out_over | ({1'b0, total_sat} > LIMIT_X);
    end
  end

endmodule
